// File: rtl/fb_pkg.sv
// fb_pkg: shared constants for the dot frame-buffer write engine.
//   COLS/ROWS  dot grid geometry (display reads addr = row*COLS + col)
//   AW         frame-buffer address width
//   FB_SIZE    number of dots in the buffer
//   OP_*       command op-codes carried on cmd_op
//   fb_state_t FSM state encoding for fb_writer
package fb_pkg;
  localparam int COLS    = 200;
  localparam int ROWS    = 150;
  localparam int AW      = 15;
  localparam int FB_SIZE = COLS * ROWS;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_PLOT  = 2'b01;
  localparam logic [1:0] OP_HLINE = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLOT,
    ST_LINE,
    ST_FILL,
    ST_FIN
  } fb_state_t;
endpackage

// File: rtl/fb_if.sv
// fb_if: drawing-command channel (valid/ready).
//   cmd_valid/cmd_ready  handshake, transfer on valid & ready
//   cmd_op               NOP/PLOT/HLINE/FILL
//   cmd_x, cmd_y         start column, row
//   cmd_len              HLINE length in dots
//   cmd_dot              value to write
// master = command source, slave = fb_writer.
interface fb_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_x;
  logic [7:0] cmd_y;
  logic [7:0] cmd_len;
  logic       cmd_dot;

  modport master (output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, cmd_dot,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, cmd_dot,
                  output cmd_ready);
endinterface

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: loadable write-address counter.
//   i_load/i_load_val/i_term_val  start address and final address of a run
//   i_inc                         advance by one
//   o_addr                        current (registered) address
//   o_last                        o_addr has reached the final address
// The counter register is the RAM port-A address itself, so it holds its
// value whenever nothing loads or increments it.
module fb_addr_gen import fb_pkg::*; (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_val,
  input  logic [AW-1:0] i_term_val,
  input  logic          i_inc,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_term;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr <= '0;
      r_term <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
      r_term <= i_term_val;
    end else if (i_inc) begin
      r_addr <= r_addr + AW'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_addr == r_term);
endmodule

// File: rtl/fb_writer.sv
// fb_writer: write-side engine for the COLS x ROWS 1-bit dot frame buffer.
//   clk, rstn        clock, async active-low reset
//   cmd              fb_if.slave command channel
//   we/waddr/wdata   RAM port-A write strobe, one dot per cycle
//   done             one-cycle pulse when a command completes or is dropped
//   err              sticky: a PLOT/HLINE was dropped for bad coordinates
// Row base y*COLS is formed once at accept; runs then just count up.
module fb_writer import fb_pkg::*; (
  input  logic          clk,
  input  logic          rstn,
  fb_if.slave           cmd,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic          wdata,
  output logic          done,
  output logic          err
);
  fb_state_t r_state;
  logic      r_ready, r_we, r_wdata, r_done, r_err;

  logic          w_accept, w_oob, w_drop, w_writes, w_load, w_inc, w_last;
  logic [8:0]    w_xend;
  logic [7:0]    w_endcol;
  logic [AW-1:0] w_base, w_start, w_line_term, w_load_val, w_term_val;

  assign w_accept = cmd.cmd_valid & r_ready;
  assign w_oob    = (cmd.cmd_x >= 8'(COLS)) || (cmd.cmd_y >= 8'(ROWS));
  assign w_drop   = w_oob && (cmd.cmd_op == OP_PLOT || cmd.cmd_op == OP_HLINE);
  assign w_writes = (cmd.cmd_op == OP_FILL) ||
                    (cmd.cmd_op == OP_PLOT  && !w_oob) ||
                    (cmd.cmd_op == OP_HLINE && !w_oob && cmd.cmd_len != 8'd0);
  assign w_load   = w_accept && w_writes;

  // 9-bit end column so x+len cannot wrap; anything past the edge is clipped.
  assign w_xend      = {1'b0, cmd.cmd_x} + {1'b0, cmd.cmd_len};
  assign w_endcol    = (w_xend > 9'(COLS)) ? 8'(COLS - 1) : 8'(w_xend - 9'd1);
  assign w_base      = AW'(cmd.cmd_y) * AW'(COLS);
  assign w_start     = w_base + AW'(cmd.cmd_x);
  assign w_line_term = w_base + AW'(w_endcol);

  always_comb begin
    w_load_val = w_start;
    w_term_val = w_start;
    if (cmd.cmd_op == OP_FILL) begin
      w_load_val = '0;
      w_term_val = AW'(FB_SIZE - 1);
    end else if (cmd.cmd_op == OP_HLINE) begin
      w_term_val = w_line_term;
    end
  end

  assign w_inc = (r_state == ST_LINE || r_state == ST_FILL) && !w_last;

  fb_addr_gen u_addr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_term_val(w_term_val),
    .i_inc     (w_inc),
    .o_addr    (waddr),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_wdata <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_ready <= 1'b0;
          if (w_writes) begin
            r_we    <= 1'b1;
            r_wdata <= cmd.cmd_dot;
            case (cmd.cmd_op)
              OP_FILL:  r_state <= ST_FILL;
              OP_HLINE: r_state <= ST_LINE;
              default:  r_state <= ST_PLOT;
            endcase
          end else begin
            // NOP, zero-length line or dropped command: no write at all
            r_state <= ST_FIN;
            r_done  <= 1'b1;
            if (w_drop) r_err <= 1'b1;
          end
        end
        ST_PLOT: begin
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_FIN;
        end
        ST_LINE, ST_FILL: if (w_last) begin
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_FIN;
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = r_ready;
  assign we            = r_we;
  assign wdata         = r_wdata;
  assign done          = r_done;
  assign err           = r_err;
endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer: directed checks of fb_writer with hand-computed expectations.
module tb_fb_writer;
  import fb_pkg::*;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          we, wdata, done, err;
  logic [AW-1:0] waddr;
  int            cyc = 0;
  int            n_chk = 0, n_pass = 0;
  int            wa[$], wd[$], wc[$], dc[$];

  fb_if bus();

  fb_writer dut (
    .clk  (clk),
    .rstn (rstn),
    .cmd  (bus),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // write / done log, sampled mid-cycle
  always @(negedge clk) begin
    if (we) begin
      wa.push_back(int'(waddr));
      wd.push_back(int'(wdata));
      wc.push_back(cyc);
    end
    if (done) dc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); wc.delete(); dc.delete();
  endtask

  // drive a command, return the cycle stamp of the accept (first write cycle)
  task automatic send(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] len, input logic dot, output int acc);
    int b = 0;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_x = x; bus.cmd_y = y; bus.cmd_len = len; bus.cmd_dot = dot;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && b < 40000) begin @(negedge clk); b++; end
    if (!bus.cmd_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int t);
    int b = 0;
    while (!bus.cmd_ready && b < 40000) begin @(negedge clk); b++; end
    if (!bus.cmd_ready) chk("idle_timeout", 0, 1);
    t = cyc;
  endtask

  initial begin
    int a, t, ok, n0;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_x = '0; bus.cmd_y = '0;
    bus.cmd_len = '0; bus.cmd_dot = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;
    @(negedge clk);

    // PLOT (5,2) -> 405
    clr();
    send(OP_PLOT, 8'd5, 8'd2, 8'd0, 1'b1, a);
    wait_idle(t);
    chk("plot_nwr", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("plot_addr", wa[0], 405);
      chk("plot_data", wd[0], 1);
      chk("plot_wcyc", wc[0], a);
    end
    chk("plot_ndone", dc.size(), 1);
    if (dc.size() > 0) chk("plot_done_cyc", dc[0], a + 1);
    chk("plot_ready_cyc", t, a + 2);

    // HLINE inside the row: (10,3) len 4 dot 0 -> 610..613
    clr();
    send(OP_HLINE, 8'd10, 8'd3, 8'd4, 1'b0, a);
    wait_idle(t);
    chk("hl_nwr", wa.size(), 4);
    ok = 1;
    foreach (wa[i]) if (wa[i] != 610 + i || wd[i] != 0 || wc[i] != a + i) ok = 0;
    chk("hl_seq", ok, 1);
    chk("hl_waddr_hold", waddr, 613);

    // HLINE len 0 -> nothing written, done immediately
    clr();
    send(OP_HLINE, 8'd7, 8'd7, 8'd0, 1'b1, a);
    wait_idle(t);
    chk("hl0_nwr", wa.size(), 0);
    chk("hl0_done_n", dc.size(), 1);
    if (dc.size() > 0) chk("hl0_done_cyc", dc[0], a);

    // clipped HLINE (190,149) len 20 -> 29990..29999
    clr();
    send(OP_HLINE, 8'd190, 8'd149, 8'd20, 1'b1, a);
    wait_idle(t);
    chk("clip_nwr", wa.size(), 10);
    ok = 1;
    foreach (wa[i]) if (wa[i] != 29990 + i || wd[i] != 1 || wc[i] != a + i) ok = 0;
    chk("clip_seq", ok, 1);
    chk("clip_err", err, 0);
    chk("clip_ndone", dc.size(), 1);
    if (dc.size() > 0) chk("clip_done_cyc", dc[0], a + 10);
    chk("clip_waddr_hold", waddr, 29999);

    // out-of-range drops
    clr();
    send(OP_PLOT, 8'd200, 8'd0, 8'd0, 1'b1, a);
    wait_idle(t);
    chk("drop1_nwr", wa.size(), 0);
    if (dc.size() > 0) chk("drop1_done_cyc", dc[0], a);
    chk("drop1_err", err, 1);
    chk("drop1_ready_cyc", t, a + 1);
    clr();
    send(OP_HLINE, 8'd0, 8'd150, 8'd5, 1'b1, a);
    wait_idle(t);
    chk("drop2_nwr", wa.size(), 0);
    if (dc.size() > 0) chk("drop2_done_cyc", dc[0], a);
    chk("drop2_err", err, 1);
    chk("drop_waddr_hold", waddr, 29999);

    // FILL dot 0 with a PLOT (0,0) queued behind it on a held valid
    clr();
    send(OP_FILL, 8'd9, 8'd9, 8'd9, 1'b0, a);
    bus.cmd_op = OP_PLOT; bus.cmd_x = 8'd0; bus.cmd_y = 8'd0; bus.cmd_dot = 1'b1;
    bus.cmd_valid = 1'b1;
    wait_idle(t);
    chk("fill_ready_cyc", t, a + 30001);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_idle(t);
    chk("fill_nwr", wa.size(), 30001);
    ok = 1;
    for (int i = 0; i < 30000 && i < wa.size(); i++)
      if (wa[i] != i || wd[i] != 0 || wc[i] != a + i) ok = 0;
    chk("fill_seq", ok, 1);
    if (wa.size() == 30001) begin
      chk("q_plot_addr", wa[30000], 0);
      chk("q_plot_data", wd[30000], 1);
      chk("q_plot_cyc", wc[30000], a + 30002);
    end
    chk("fill_ndone", dc.size(), 2);
    if (dc.size() > 0) chk("fill_done_cyc", dc[0], a + 30000);

    // reset during the 100th FILL write
    clr();
    send(OP_FILL, 8'd0, 8'd0, 8'd0, 1'b1, a);
    for (int b = 0; b < 200 && wa.size() < 100; b++) begin @(negedge clk); #1; end
    chk("mid_reached", wa.size(), 100);
    rstn = 1'b0;
    #1;
    chk("mid_we_async", we, 0);
    chk("mid_waddr", waddr, 0);
    n0 = wa.size();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_ready", bus.cmd_ready, 1);
    chk("post_done", done, 0);
    chk("post_err", err, 0);
    chk("post_nwr", wa.size(), n0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
